// File: rtl/cpu_pkg.sv
// Shared RV32I front-end types and constants used by the fetch stage and its FIFOs.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a single-cycle flush; holds pending PCs or fetched instructions.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = logic [31:0],
  localparam int AW = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  T                 wdata_i,
  output T                 rdata_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC generation, credit-limited imem requests, response
// buffering and a valid/ready hand-off to decode, with EX redirects flushing stale fetches.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] pend_count, buf_count, in_use;
  logic [XLEN-1:0]  pend_head;
  fetch_entry_t     buf_head, buf_wdata;
  logic             accept, resp_keep, pop;

  // A buffered entry leaving this cycle frees its credit now, which keeps a
  // 1-cycle memory streaming one instruction per cycle.
  assign pop       = if_valid && id_ready;
  assign in_use    = out_q + buf_count - CNT_W'(pop);
  assign imem_req_valid = !reset && !redirect_valid && (in_use < CNT_W'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept    = imem_req_valid && imem_req_ready;
  assign resp_keep = imem_resp_valid && (drop_q == '0) && !redirect_valid;
  assign buf_wdata = '{pc: pend_head, instr: imem_resp_data};

  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pend_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (accept),
    .pop_i   (resp_keep),
    .wdata_i (pc_q),
    .rdata_o (pend_head),
    .count_o (pend_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_buf (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (resp_keep),
    .pop_i   (pop),
    .wdata_i (buf_wdata),
    .rdata_o (buf_head),
    .count_o (buf_count)
  );

  // Every request still in flight at a redirect belongs to the old path and is
  // counted off as a drop; a response landing in the redirect cycle is itself dropped.
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CNT_W'(accept) - CNT_W'(imem_resp_valid);
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      drop_d = out_q - CNT_W'(imem_resp_valid);
    end else begin
      if (accept) pc_d = pc_q + XLEN'(4);
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  assign if_valid = (buf_count != '0);
  assign if_pc    = if_valid ? buf_head.pc : '0;
  assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;

  assert property (@(posedge clk) disable iff (reset) imem_resp_valid |-> (out_q != '0));
  assert property (@(posedge clk) disable iff (reset) resp_keep |-> (pend_count != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order imem model with programmable latency and a PC/instruction scoreboard.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          pop_edge[$];
  int          lat = 1;
  int          edge_n = 0;
  int          max_out = 0;
  int          cur_out;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'd5) ^ 32'h3;
  endfunction

  // Memory: accept sampled mid-cycle, response presented lat cycles later, in order.
  always @(negedge clk) begin
    if (!reset) begin
      cur_out = mem_q.size() + (imem_resp_valid ? 1 : 0);
      if (cur_out > max_out) max_out = cur_out;
      if (imem_req_valid && imem_req_ready)
        mem_q.push_back('{addr: imem_req_addr, due: edge_n + lat});
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else begin
      edge_n++;
      #1;
      if (mem_q.size() != 0 && mem_q[0].due <= edge_n) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(mem_q[0].addr);
        mem_q.delete(0);
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // Scoreboard: every decode hand-off must match the next expected PC.
  always @(negedge clk) begin
    if (!reset && if_valid && id_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got pc=%h, required no instruction", if_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (if_pc !== exp_pc || if_instr !== instr_of(exp_pc)) begin
          errors++;
          $display("FAIL pop_order got pc=%h instr=%h, required pc=%h instr=%h",
                   if_pc, if_instr, exp_pc, instr_of(exp_pc));
        end
      end
      pop_edge.push_back(edge_n);
    end
  end

  task automatic fill_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset(input int l);
    reset = 1'b1;
    lat = l;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    exp_q.delete();
    pop_edge.delete();
    max_out = 0;
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pop_edge.size() >= n) break;
      @(posedge clk);
      #2;
    end
    if (pop_edge.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b required 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b required 0", imem_req_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got %h required 0", if_pc); end
    checks++; if (if_instr !== NOP) begin errors++; $display("FAIL rst_if_instr got %h required %h", if_instr, NOP); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h required 0", imem_req_addr); end
    @(posedge clk);
    #2;
    fill_exp(32'h0, 8);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_first_req got valid=%b addr=%h required valid=1 addr=0", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    bit ok;
    int rel;
    do_reset(1);
    rel = edge_n;
    fill_exp(32'h0, 16);
    wait_pops(4, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got %0d pops required 4", pop_edge.size()); end
    if (ok) begin
      checks++;
      if (pop_edge[0] != rel + 2) begin errors++; $display("FAIL stream_first_latency got edge %0d required %0d", pop_edge[0], rel + 2); end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (pop_edge[i] - pop_edge[i-1] != 1) begin
          errors++;
          $display("FAIL stream_bubble at pop %0d got gap %0d required 1", i, pop_edge[i] - pop_edge[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit found;
    do_reset(1);
    fill_exp(32'h0, 16);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (if_valid && if_pc == 32'h8) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_reach_pc8 got pc=%h required 00000008", if_pc); end
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== instr_of(32'h8)) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b pc=%h instr=%h required 1/00000008/%h",
                 i, if_valid, if_pc, if_instr, instr_of(32'h8));
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_credit cycle %0d got req_valid=%b required 0", i, imem_req_valid);
      end
    end
    @(posedge clk);
    #2;
    id_ready = 1'b1;
    wait_pops(5, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_resume got %0d pops required 5", pop_edge.size()); end
  endtask

  task automatic test_latency3();
    bit ok;
    do_reset(3);
    fill_exp(32'h0, 16);
    wait_pops(4, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lat3_timeout got %0d pops required 4", pop_edge.size()); end
    checks++; if (max_out != 2) begin errors++; $display("FAIL lat3_outstanding got %0d required 2", max_out); end
    if (ok) begin
      checks++;
      if (pop_edge[1] - pop_edge[0] != 1) begin
        errors++;
        $display("FAIL lat3_pair_gap got %0d required 1", pop_edge[1] - pop_edge[0]);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    bit ok;
    bit found;
    do_reset(3);
    fill_exp(32'h0, 16);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (mem_q.size() + (imem_resp_valid ? 1 : 0) == 2) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL redir_inflight_setup got %0d in flight required 2", mem_q.size()); end
    // Low address bits of the target must be ignored.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    exp_q.delete();
    fill_exp(32'h100, 16);
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_inflight_req got %b required 0", imem_req_valid); end
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    wait_pops(2, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL redir_inflight_timeout got %0d pops required 2", pop_edge.size()); end
  endtask

  task automatic test_redirect_collide();
    bit ok;
    int base;
    do_reset(1);
    fill_exp(32'h0, 64);
    wait_pops(3, 20, ok);
    @(posedge clk);
    #2;
    checks++;
    if (imem_resp_valid !== 1'b1 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL collide_setup got resp=%b if_valid=%b required 1/1", imem_resp_valid, if_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    exp_q.delete();
    fill_exp(32'h100, 16);
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL collide_req_withdrawn got %b required 0", imem_req_valid); end
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    base = pop_edge.size();
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL collide_flush got if_valid=%b required 0", if_valid); end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL collide_first_req got valid=%b addr=%h required 1/00000100", imem_req_valid, imem_req_addr);
    end
    wait_pops(base + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL collide_timeout got %0d pops required %0d", pop_edge.size(), base + 2); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset(1);
    fill_exp(32'h0, 64);
    wait_pops(3, 20, ok);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL areset_if_valid got %b required 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL areset_req_valid got %b required 0", imem_req_valid); end
    @(posedge clk);
    @(posedge clk);
    #2;
    exp_q.delete();
    pop_edge.delete();
    fill_exp(32'h0, 16);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL areset_restart got valid=%b addr=%h required 1/00000000", imem_req_valid, imem_req_addr);
    end
    wait_pops(3, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL areset_timeout got %0d pops required 3", pop_edge.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency3();
    test_redirect_inflight();
    test_redirect_collide();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
